mem_byte_bridge: RTL

MEM_BYTE_BRIDGE -- requirements
Module: mem_byte_bridge

---
 rtl/mem_byte_bridge.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_byte_bridge.sv
// Bridges 32-bit CPU word/byte loads and stores onto a byte-wide synchronous memory port.
// Words are moved little-endian, one byte per cycle; misaligned word accesses are rejected.
module mem_byte_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        isbyte,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StXfer,
    StTail,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        isbyte_q, isbyte_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] buf_q, buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  last_idx;

  assign last_idx = isbyte_q ? 2'd0 : 2'd3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      isbyte_q <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      isbyte_q <= isbyte_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    isbyte_d = isbyte_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d     = we;
          isbyte_d = isbyte;
          wdata_d  = wdata;
          cnt_d    = 2'd0;
          base_d   = isbyte ? addr : {addr[31:2], 2'b00};
          state_d  = (!isbyte && (addr[1:0] != 2'b00)) ? StErr : StXfer;
        end
      end
      StXfer: begin
        // Memory read data lags the strobe by one cycle, so store the previous byte.
        if (!we_q) begin
          unique case (cnt_q)
            2'd1:    buf_d[7:0]   = mem_rdata;
            2'd2:    buf_d[15:8]  = mem_rdata;
            2'd3:    buf_d[23:16] = mem_rdata;
            default: ;
          endcase
        end
        if (cnt_q == last_idx) begin
          state_d = we_q ? StDone : StTail;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StTail: begin
        rdata_d = isbyte_q ? {{24{mem_rdata[7]}}, mem_rdata} : {mem_rdata, buf_q};
        state_d = StDone;
      end
      StDone: begin
        cnt_d   = 2'd0;
        state_d = StIdle;
      end
      StErr: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata     = rdata_q;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone) || (state_q == StErr);
    err       = (state_q == StErr);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == StXfer) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_addr  = base_q + {30'b0, cnt_q};
      mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
    end
  end

endmodule
